// File: rtl/usr_barrel_if.sv
// Bus bundle for usr_barrel: command inputs and register/serial outputs.
interface usr_barrel_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               en;
  logic [2:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic               s_in_r;
  logic               s_in_l;
  logic [WIDTH-1:0]   p_in;
  logic [WIDTH-1:0]   p_out;
  logic               r_out;
  logic               l_out;
  logic               busy;
  logic               done;

  modport master (
    output en, mode, shamt, s_in_r, s_in_l, p_in,
    input  p_out, r_out, l_out, busy, done
  );

  modport slave (
    input  en, mode, shamt, s_in_r, s_in_l, p_in,
    output p_out, r_out, l_out, busy, done
  );
endinterface

// File: rtl/usr_barrel.sv
// Universal shift register: barrel shifts/rotates, arithmetic shift and
// an LSB-first serial burst driven by a two-state FSM.
module usr_barrel #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst,
  usr_barrel_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_SAR   = 3'b110;
  localparam logic [2:0] M_BURST = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] p_q, p_n;
  logic             done_q, done_n;

  // Shift amounts >= WIDTH fall out naturally: plain shifts yield all-fill,
  // and the rotate amount is reduced modulo WIDTH first.
  function automatic logic [WIDTH-1:0] op_result(
    input logic [2:0]         m,
    input logic [SHAMT_W-1:0] sh,
    input logic               sr,
    input logic               sl,
    input logic [WIDTH-1:0]   pin,
    input logic [WIDTH-1:0]   cur
  );
    logic [WIDTH-1:0]        ones, r;
    logic signed [WIDTH-1:0] cur_s;
    logic [SHAMT_W-1:0]      amt;
    logic [2*WIDTH-1:0]      dbl, rl;
    ones  = {WIDTH{1'b1}};
    cur_s = cur;
    amt   = SHAMT_W'(sh % WIDTH);
    dbl   = {cur, cur};
    rl    = dbl << amt;
    r     = cur;
    case (m)
      M_SHR:  r = (cur >> sh) | ({WIDTH{sr}} & ~(ones >> sh));
      M_SHL:  r = (cur << sh) | ({WIDTH{sl}} & ~(ones << sh));
      M_LOAD: r = pin;
      M_ROR:  r = WIDTH'(dbl >> amt);
      M_ROL:  r = rl[2*WIDTH-1:WIDTH];
      M_SAR:  r = cur_s >>> sh;
      default: r = cur;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      p_q    <= p_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_n     = p_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en) begin
          if (bus.mode == M_BURST) begin
            p_n     = bus.p_in;
            cnt_n   = CNT_W'(WIDTH - 1);
            state_n = SHIFT;
          end else if (bus.mode != M_HOLD) begin
            p_n = op_result(bus.mode, bus.shamt, bus.s_in_r, bus.s_in_l, bus.p_in, p_q);
          end
        end
      end
      SHIFT: begin
        // Commands are ignored until the burst finishes.
        if (cnt != '0) begin
          p_n   = {bus.s_in_r, p_q[WIDTH-1:1]};
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.p_out = p_q;
  assign bus.r_out = p_q[0];
  assign bus.l_out = p_q[WIDTH-1];
  assign bus.busy  = (state == SHIFT);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_usr_barrel.sv
// Self-checking bench for usr_barrel (WIDTH=8): directed vector table,
// burst sequences and randomized single-cycle ops against a bit-level model.
module tb_usr_barrel;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usr_barrel_if #(.WIDTH(W)) bif ();
  usr_barrel #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [2:0] shamt;
    logic       sr;
    logic       sl;
    logic [7:0] pin;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [2:0] m, input logic [2:0] sh,
                       input logic sr, input logic sl, input logic [7:0] pin);
    bif.en = en; bif.mode = m; bif.shamt = sh;
    bif.s_in_r = sr; bif.s_in_l = sl; bif.p_in = pin;
  endtask

  // Reference: each result bit computed from where it comes from.
  function automatic logic [7:0] model(input logic en, input logic [2:0] m, input int sh,
                                       input logic sr, input logic sl,
                                       input logic [7:0] pin, input logic [7:0] cur);
    logic [7:0] r;
    r = cur;
    if (!en) return cur;
    for (int i = 0; i < W; i++) begin
      case (m)
        3'd1: r[i] = (i + sh < W) ? cur[i + sh] : sr;
        3'd2: r[i] = (i - sh >= 0) ? cur[i - sh] : sl;
        3'd3: r[i] = pin[i];
        3'd4: r[i] = cur[(i + sh) % W];
        3'd5: r[i] = cur[(i - (sh % W) + W) % W];
        3'd6: r[i] = (i + sh < W) ? cur[i + sh] : cur[W-1];
        default: r[i] = cur[i];
      endcase
    end
    return r;
  endfunction

  // Runs a full burst of 'pin' while applying junk on the command inputs.
  task automatic burst(input string tag, input logic [7:0] pin, input bit junk);
    logic [7:0] bits;
    bits = pin;
    drive(1'b1, 3'b111, 3'd0, 1'b0, 1'b0, pin);
    step();
    for (int k = 0; k < W; k++) begin
      chk({tag, "_busy"}, bif.busy, 1'b1);
      chk({tag, "_bit"}, bif.r_out, bits[k]);
      chk({tag, "_nodone"}, bif.done, 1'b0);
      if (junk) drive(1'($urandom), 3'($urandom), 3'($urandom), 1'b0, 1'($urandom), 8'($urandom));
      else      drive(1'b0, 3'b000, 3'd0, 1'b0, 1'b0, 8'h00);
      if (junk && k == 2) bif.mode = 3'b111;
      if (junk && k == 2) bif.en = 1'b1;
      step();
    end
  endtask

  logic [7:0] ref_p;

  initial begin
    rst = 1'b1;
    drive(1'b1, 3'b011, 3'd0, 1'b0, 1'b0, 8'hFF);
    step();
    chk("rst_pout", bif.p_out, 8'h00);
    chk("rst_busy", bif.busy, 1'b0);
    chk("rst_done", bif.done, 1'b0);
    rst = 1'b0;

    vecs.push_back('{1, 3'b011, 0, 0, 0, 8'hB4, 8'hB4});
    vecs.push_back('{1, 3'b001, 3, 1, 0, 8'h00, 8'hF6});
    vecs.push_back('{1, 3'b010, 2, 0, 0, 8'h00, 8'hD8});
    vecs.push_back('{1, 3'b100, 4, 0, 0, 8'h00, 8'h8D});
    vecs.push_back('{1, 3'b110, 7, 0, 0, 8'h00, 8'hFF});
    vecs.push_back('{1, 3'b011, 0, 0, 0, 8'h96, 8'h96});
    vecs.push_back('{0, 3'b011, 0, 0, 0, 8'h11, 8'h96});
    vecs.push_back('{0, 3'b111, 0, 0, 0, 8'h22, 8'h96});
    vecs.push_back('{1, 3'b000, 5, 1, 1, 8'h33, 8'h96});
    vecs.push_back('{1, 3'b100, 0, 1, 1, 8'h44, 8'h96});
    vecs.push_back('{1, 3'b001, 0, 1, 1, 8'h55, 8'h96});
    vecs.push_back('{1, 3'b101, 3, 0, 0, 8'h00, 8'hB4});
    vecs.push_back('{1, 3'b011, 0, 0, 0, 8'h5A, 8'h5A});
    vecs.push_back('{1, 3'b110, 2, 1, 1, 8'h00, 8'h16});
    vecs.push_back('{1, 3'b010, 3, 0, 1, 8'h00, 8'hB7});
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].shamt, vecs[i].sr, vecs[i].sl, vecs[i].pin);
      step();
      chk($sformatf("vec%0d", i), bif.p_out, vecs[i].exp);
      chk($sformatf("vec%0d_busy", i), bif.busy, 1'b0);
    end

    // Plain burst, then done pulse and final register contents.
    burst("a5", 8'hA5, 1'b0);
    chk("a5_done", bif.done, 1'b1);
    chk("a5_idle", bif.busy, 1'b0);
    chk("a5_pout", bif.p_out, 8'h01);
    step();
    chk("a5_done_once", bif.done, 1'b0);
    chk("a5_still_idle", bif.busy, 1'b0);

    // Inputs toggled, including a second 111, while busy.
    burst("imm", 8'hA5, 1'b1);
    chk("imm_done", bif.done, 1'b1);
    drive(1'b0, 3'b000, 3'd0, 1'b0, 1'b0, 8'h00);
    step();
    chk("imm_done_once", bif.done, 1'b0);
    chk("imm_no_requeue", bif.busy, 1'b0);

    // Back-to-back: second burst accepted in the done cycle.
    burst("b2b1", 8'hA5, 1'b0);
    chk("b2b_gap_done", bif.done, 1'b1);
    chk("b2b_gap_busy", bif.busy, 1'b0);
    burst("b2b2", 8'h3C, 1'b0);
    chk("b2b2_done", bif.done, 1'b1);
    step();

    // Reset at busy cycle 3 aborts without done.
    drive(1'b1, 3'b111, 3'd0, 1'b1, 1'b0, 8'hC3);
    step();
    drive(1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 8'h00);
    step(); step(); step();
    chk("abort_busy_before", bif.busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", bif.busy, 1'b0);
    chk("abort_pout", bif.p_out, 8'h00);
    for (int k = 0; k < W + 2; k++) begin
      chk("abort_nodone", bif.done, 1'b0);
      step();
    end

    // Randomized single-cycle ops vs. bit-level model.
    ref_p = 8'h00;
    for (int i = 0; i < 300; i++) begin
      logic en, sr, sl;
      logic [2:0] m, sh;
      logic [7:0] pin;
      en = ($urandom_range(0, 7) != 0);
      m = 3'($urandom_range(0, 6));
      sh = 3'($urandom);
      sr = 1'($urandom); sl = 1'($urandom);
      pin = 8'($urandom);
      drive(en, m, sh, sr, sl, pin);
      step();
      ref_p = model(en, m, int'(sh), sr, sl, pin, ref_p);
      chk($sformatf("rnd%0d_m%0d_s%0d", i, m, sh), bif.p_out, ref_p);
      chk("rnd_rout", bif.r_out, ref_p[0]);
      chk("rnd_lout", bif.l_out, ref_p[W-1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
